// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner of the 8-digit hex display with dwell and digit scan
// Build option: DISP_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.

module display_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SCAN_DIV = 16,
  parameter int DWELL    = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  val,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic [7:0]             an,
  output logic [7:0]             seg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);
  localparam logic [PW-1:0] SCAN_MAX  = PW'(SCAN_DIV - 1);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t            r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_rr;
  logic              r_busy;
  logic [DW-1:0]     r_dwell;
  logic [PW-1:0]     r_presc;
  logic [2:0]        r_pos;
  logic [7:0]        r_an;
  logic [7:0]        r_seg;

  logic [IW:0]       w_first;
  logic [IW:0]       w_next;
  logic              w_owner_req;
  logic              w_handoff;
  logic [31:0]       w_shown;
  logic [3:0]        w_nib;
  logic              w_blank;

  // {found, index} of the first set bit among cnt entries starting at start (wrapping)
  function automatic logic [IW:0] f_pick(input logic [NUM_REQ-1:0] r, input int start, input int cnt);
    logic [IW:0]   res;
    logic [IW-1:0] k;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IW'((start + i) % NUM_REQ);
      if (i < cnt && r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] x);
    return (int'(x) + 1 == NUM_REQ) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IW-1:0] x);
    logic [NUM_REQ-1:0] o;
    o = '0;
    o[x] = 1'b1;
    return o;
  endfunction

  function automatic logic [7:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  always_comb begin
    w_first     = f_pick(req, int'(r_rr), NUM_REQ);
    w_next      = f_pick(req, int'(f_inc(r_owner)), NUM_REQ - 1);
    w_owner_req = req[r_owner];
    // an early drop hands off immediately; a held owner yields only once dwell saturates
    w_handoff   = (!w_owner_req || r_dwell == DWELL_MAX) && w_next[IW];
  end

  always_comb begin
    w_shown = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IW'(i)) w_shown = val[32*i +: 32];
    end
    w_nib = w_shown[{r_pos, 2'b00} +: 4];
  end

`ifdef DISP_LEADING_ZERO_BLANK_EN
  logic [2:0] w_msd;

  always_comb begin
    w_msd = '0;
    for (int k = 1; k < 8; k++) begin
      if (w_shown[4*k +: 4] != 4'h0) w_msd = 3'(k);
    end
  end

  assign w_blank = (r_pos > w_msd);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_rr    <= '0;
      r_busy  <= 1'b0;
      r_dwell <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_first[IW]) begin
            r_gnt   <= f_onehot(w_first[IW-1:0]);
            r_owner <= w_first[IW-1:0];
            r_rr    <= f_inc(w_first[IW-1:0]);
            r_busy  <= 1'b1;
            r_dwell <= '0;
            r_state <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (w_handoff) begin
            r_gnt   <= f_onehot(w_next[IW-1:0]);
            r_owner <= w_next[IW-1:0];
            r_rr    <= f_inc(w_next[IW-1:0]);
            r_dwell <= '0;
          end else if (!w_owner_req) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_dwell <= '0;
            r_state <= S_IDLE;
          end else if (r_dwell != DWELL_MAX) begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_pos   <= '0;
    end else if (r_presc == SCAN_MAX) begin
      r_presc <= '0;
      r_pos   <= r_pos + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // digit drive follows pos with one register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
    end else if (r_state == S_SHOW && !w_blank) begin
      r_an  <= ~(8'h01 << r_pos);
      r_seg <= f_seg(w_nib);
    end else begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
    end
  end

  assign gnt   = r_gnt;
  assign owner = 3'(r_owner);
  assign busy  = r_busy;
  assign an    = r_an;
  assign seg   = r_seg;

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - randomized scoreboard bench for display_arbiter
// Honours DISP_LEADING_ZERO_BLANK_EN when defined for the build.

module tb_display_arbiter;

  localparam int NR = 4;
  localparam int SD = 4;
  localparam int DW = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [32*NR-1:0] val = '0;
  logic [NR-1:0]  gnt;
  logic [2:0]     owner;
  logic           busy;
  logic [7:0]     an;
  logic [7:0]     seg;

  display_arbiter #(.NUM_REQ(NR), .SCAN_DIV(SD), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .val(val),
    .gnt(gnt), .owner(owner), .busy(busy), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [2:0]    owner;
    logic          busy;
    logic [7:0]    an;
    logic [7:0]    seg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // reference model: owner, how long it has held the display, and cycles since reset for the scan
  bit         started = 0;
  int         m_owner = 0, m_busy = 0, m_held = 0, m_rr = 0, m_tick = 0;
  logic [7:0] m_an = 8'hFF, m_seg = 8'hFF;

  always @(posedge clk) begin
    int pos, msd, first, nxt;
    logic [31:0] shown;
    logic [7:0]  one;
    exp_t e;
    if (rst) begin
      started = 1;
      m_owner = 0; m_busy = 0; m_held = 0; m_rr = 0; m_tick = 0;
      m_an = 8'hFF; m_seg = 8'hFF;
    end else if (started) begin
      pos = (m_tick / SD) % 8;
      shown = val[32*m_owner +: 32];
      msd = 7;
`ifdef DISP_LEADING_ZERO_BLANK_EN
      msd = 0;
      for (int k = 1; k < 8; k++) if (((shown >> (4*k)) & 32'hF) != 0) msd = k;
`endif
      if (m_busy != 0 && pos <= msd) begin
        one = 8'h01;
        m_an = ~(one << pos);
        m_seg = glyph[(shown >> (4*pos)) & 32'hF];
      end else begin
        m_an = 8'hFF;
        m_seg = 8'hFF;
      end
      m_tick++;
      first = -1;
      for (int i = NR - 1; i >= 0; i--) if (req[(m_rr + i) % NR]) first = (m_rr + i) % NR;
      nxt = -1;
      for (int i = NR - 1; i >= 1; i--) if (req[(m_owner + i) % NR]) nxt = (m_owner + i) % NR;
      if (m_busy == 0) begin
        if (first >= 0) begin
          m_owner = first; m_busy = 1; m_held = 0; m_rr = (first + 1) % NR;
        end
      end else if (!req[m_owner] || m_held == DW - 1) begin
        if (nxt >= 0) begin
          m_owner = nxt; m_held = 0; m_rr = (nxt + 1) % NR;
        end else if (!req[m_owner]) begin
          m_busy = 0;
        end
      end else begin
        m_held++;
      end
    end
    if (started) begin
      e.gnt   = (m_busy != 0) ? NR'(1 << m_owner) : '0;
      e.owner = 3'(m_owner);
      e.busy  = (m_busy != 0);
      e.an    = m_an;
      e.seg   = m_seg;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      pops++;
      chk("sb_gnt", 32'(gnt), 32'(e.gnt));
      chk("sb_owner", 32'(owner), 32'(e.owner));
      chk("sb_busy", 32'(busy), 32'(e.busy));
      chk("sb_an", 32'(an), 32'(e.an));
      chk("sb_seg", 32'(seg), 32'(e.seg));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic wait_change(input string nm, input logic [NR-1:0] from, input logic [NR-1:0] to);
    int n;
    n = 0;
    while (gnt == from && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_cycles"}, 32'(n), 32'(DW));
    chk({nm, "_gnt"}, 32'(gnt), 32'(to));
  endtask

  initial begin
    logic [7:0] lit;
    int k;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(200);
    chk("idle_an", 32'(an), 32'hFF);

    val[64 +: 32] = 32'h1234_ABCD;
    req = 4'b0100;
    cyc(1);
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_owner", 32'(owner), 32'd2);
    lit = '0;
    repeat (40) begin
      cyc(1);
      lit |= ~an;
      if (an == 8'hFE) chk("t2_digit0", 32'(seg), 32'hA1);
      if (an == 8'h7F) chk("t2_digit7", 32'(seg), 32'hF9);
    end
    chk("t2_lit", 32'(lit), 32'hFF);
    req = '0;
    cyc(10);

    pulse_rst();
    req = 4'b1011;
    cyc(1);
    chk("t3_first", 32'(gnt), 32'h1);
    wait_change("t3_h1", 4'b0001, 4'b0010);
    wait_change("t3_h2", 4'b0010, 4'b1000);
    wait_change("t3_h3", 4'b1000, 4'b0001);
    req = '0;
    cyc(5);

    pulse_rst();
    req = 4'b1001;
    cyc(1);
    chk("t4_first", 32'(gnt), 32'h1);
    cyc(5);
    req[0] = 1'b0;
    cyc(1);
    chk("t4_early_gnt", 32'(gnt), 32'h8);
    chk("t4_early_busy", 32'(busy), 32'h1);
    cyc(3);
    req = '0;
    cyc(1);
    chk("t4_idle_gnt", 32'(gnt), 32'h0);
    chk("t4_idle_busy", 32'(busy), 32'h0);
    cyc(1);
    chk("t4_idle_an", 32'(an), 32'hFF);

    pulse_rst();
    req = 4'b0010;
    cyc(4);
    chk("t5_pre", 32'(gnt), 32'h2);
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_an", 32'(an), 32'hFF);
    rst = 1'b0;
    req = 4'b0011;
    cyc(1);
    chk("t5_after", 32'(gnt), 32'h1);
    req = '0;
    cyc(3);

    pulse_rst();
    val[0 +: 32] = 32'h0000_00A5;
    req = 4'b0001;
    cyc(2);
    lit = '0;
    repeat (40) begin
      cyc(1);
      lit |= ~an;
    end
`ifdef DISP_LEADING_ZERO_BLANK_EN
    chk("t6_a5_lit", 32'(lit), 32'h03);
`else
    chk("t6_a5_lit", 32'(lit), 32'hFF);
`endif
    val[0 +: 32] = 32'h0;
    cyc(1);
    lit = '0;
    repeat (40) begin
      cyc(1);
      lit |= ~an;
    end
`ifdef DISP_LEADING_ZERO_BLANK_EN
    chk("t6_zero_lit", 32'(lit), 32'h01);
`else
    chk("t6_zero_lit", 32'(lit), 32'hFF);
`endif
    req = '0;

    pulse_rst();
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, NR - 1);
        req[k] = ~req[k];
      end
      if ($urandom_range(0, 15) == 0) begin
        k = $urandom_range(0, NR - 1);
        val[32*k +: 32] = $urandom >> $urandom_range(0, 31);
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    req = '0;
    cyc(10);
    chk("sb_activity", 32'(pops > 3000), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
